// File: rtl/alu_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer: opcode constants, the
// sequencer state encoding and small opcode-classification helpers.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WAIT_W = 4;

  localparam logic [OP_W-1:0] OP_ADD        = 5'd0;
  localparam logic [OP_W-1:0] OP_AND        = 5'd1;
  localparam logic [OP_W-1:0] OP_OR         = 5'd2;
  localparam logic [OP_W-1:0] OP_SHL        = 5'd3;
  localparam logic [OP_W-1:0] OP_SHR        = 5'd4;
  localparam logic [OP_W-1:0] OP_SHRA       = 5'd5;
  localparam logic [OP_W-1:0] OP_ROL        = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR        = 5'd7;
  localparam logic [OP_W-1:0] OP_NOT        = 5'd8;
  localparam logic [OP_W-1:0] OP_NEG        = 5'd9;
  localparam logic [OP_W-1:0] OP_MUL        = 5'd10;
  localparam logic [OP_W-1:0] OP_DIV        = 5'd11;
  localparam logic [OP_W-1:0] OP_LAST_LEGAL = 5'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

  // Multiply and divide are the only ops that produce a HI/LO pair worth
  // committing to the architectural registers, and the only multi-cycle ops.
  function automatic logic op_is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the request handshake, the ALU operand/result bus, the response
// handshake and the architectural HI/LO outputs of the sequencer.
//   slave  : the sequencer side (drives req_ready, alu_*, res_*, hi_q/lo_q)
//   master : the environment side (requester, external ALU, consumer)
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_zlow;
  logic [31:0] alu_zhigh;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        res_err;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_zlow, alu_zhigh, res_ready,
    output req_ready, alu_a, alu_b, alu_op, res_valid, res_lo, res_hi, res_err,
           hi_q, lo_q
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_zlow, alu_zhigh, res_ready,
    input  req_ready, alu_a, alu_b, alu_op, res_valid, res_lo, res_hi, res_err,
           hi_q, lo_q
  );
endinterface

// File: rtl/alu_op_sequencer_hilo_regs.sv
// ---------------------------------------------------------------------------
// alu_hilo_regs
// Architectural HI/LO register pair with a shared write enable.
//   clock, clear : clock and asynchronous active-low reset
//   i_we         : load i_hi/i_lo at the next rising edge
//   o_hi_q/o_lo_q: current register contents
// ---------------------------------------------------------------------------
module alu_hilo_regs (
  input  logic        clock,
  input  logic        clear,
  input  logic        i_we,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_hi_q,
  output logic [31:0] o_lo_q
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // NOTE: state is written with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_we) begin
      r_hi <= i_hi;
      r_lo <= i_lo;
    end
  end

  assign o_hi_q = r_hi;
  assign o_lo_q = r_lo;

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Accepts one ALU request at a time, holds the operands on the external ALU
// for a per-opcode number of cycles, captures the result pair, presents it
// on a valid/ready response port and commits MUL/DIV results to HI/LO.
//   clock, clear : clock and asynchronous active-low reset
//   bus          : request, ALU, response and HI/LO signals (slave side)
//   MULDIV_WAIT  : EXEC cycles granted to MUL/DIV (1..15); other ops get 1
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned MULDIV_WAIT = 4
) (
  input  logic              clock,
  input  logic              clear,
  alu_op_sequencer_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_accept;
  logic              w_capture;
  logic              w_hilo_we;

  logic [31:0]       r_alu_a;
  logic [31:0]       r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic [31:0]       r_res_lo;
  logic [31:0]       r_res_hi;
  logic              r_res_err;
  logic [31:0]       w_hi_q;
  logic [31:0]       w_lo_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_hilo_we   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (op_is_legal(bus.req_op)) begin
            w_state_nxt = EXEC;
            w_wait_nxt  = op_is_muldiv(bus.req_op) ? WAIT_W'(MULDIV_WAIT)
                                                   : WAIT_W'(1);
          end else begin
            // Illegal opcodes skip the ALU entirely and report an error.
            w_state_nxt = RESP;
            w_wait_nxt  = '0;
          end
        end
      end
      EXEC: begin
        // r_wait counts the EXEC cycles still owed, including this one.
        if (r_wait <= WAIT_W'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt  = r_wait - WAIT_W'(1);
        end
      end
      RESP: begin
        if (bus.res_ready) begin
          w_state_nxt = IDLE;
          // r_alu_op still holds the accepted opcode until the next accept.
          w_hilo_we   = op_is_muldiv(r_alu_op) && !r_res_err;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_res_lo  <= '0;
      r_res_hi  <= '0;
      r_res_err <= 1'b0;
    end else if (w_accept) begin
      r_alu_a  <= bus.req_a;
      r_alu_b  <= bus.req_b;
      r_alu_op <= bus.req_op;
      if (!op_is_legal(bus.req_op)) begin
        r_res_lo  <= '0;
        r_res_hi  <= '0;
        r_res_err <= 1'b1;
      end
    end else if (w_capture) begin
      // The ALU result is looked at only on this edge.
      r_res_lo  <= bus.alu_zlow;
      r_res_hi  <= bus.alu_zhigh;
      r_res_err <= 1'b0;
    end
  end

  alu_hilo_regs u_hilo (
    .clock  (clock),
    .clear  (clear),
    .i_we   (w_hilo_we),
    .i_hi   (r_res_hi),
    .i_lo   (r_res_lo),
    .o_hi_q (w_hi_q),
    .o_lo_q (w_lo_q)
  );

  assign bus.req_ready = (r_state == IDLE);
  assign bus.res_valid = (r_state == RESP);
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.res_lo    = r_res_lo;
  assign bus.res_hi    = r_res_hi;
  assign bus.res_err   = r_res_err;
  assign bus.hi_q      = w_hi_q;
  assign bus.lo_q      = w_lo_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter MULDIV_WAIT, default 4, meaning EXEC cycles granted to op 10 (multiply) and op 11 (divide); legal range 1..15.
REQ-002 SHALL have port clock  input  1  single rising-edge clock.
REQ-003 SHALL have port clear  input  1  reset: asynchronous assert, active-low.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_op  input  5  ALU opcode (0..11 legal).
REQ-007 SHALL have port req_a  input  32  operand A.
REQ-008 SHALL have port req_b  input  32  operand B.
REQ-009 SHALL have port alu_a  output  32  operand A driven to the ALU.
REQ-010 SHALL have port alu_b  output  32  operand B driven to the ALU.
REQ-011 SHALL have port alu_op  output  5  opcode driven to the ALU.
REQ-012 SHALL have port alu_zlow  input  32  ALU low result word.
REQ-013 SHALL have port alu_zhigh  input  32  ALU high result word.
REQ-014 SHALL have port res_valid  output  1  result available.
REQ-015 SHALL have port res_ready  input  1  result consumed when high with res_valid.
REQ-016 SHALL have port res_lo  output  32  captured low word.
REQ-017 SHALL have port res_hi  output  32  captured high word.
REQ-018 SHALL have port res_err  output  1  request had an illegal opcode.
REQ-019 SHALL have port hi_q  output  32  architectural HI register.
REQ-020 SHALL have port lo_q  output  32  architectural LO register.

Function
REQ-021 SHALL implement states IDLE, EXEC, RESP; req_ready=1 only in IDLE; res_valid=1 only in RESP.
REQ-022 In IDLE with req_valid=1, SHALL latch req_a/req_b/req_op into alu_a/alu_b/alu_op at the edge.
REQ-023 On acceptance with legal op, SHALL enter EXEC with wait count N=MULDIV_WAIT for ops 10/11, N=1 otherwise.
REQ-024 On acceptance with op 12..31, SHALL go directly to RESP with res_err=1, res_lo=0, res_hi=0; alu_* still latched.
REQ-025 EXEC SHALL last exactly N cycles; at the final EXEC edge SHALL capture alu_zlow->res_lo, alu_zhigh->res_hi, res_err=0, and enter RESP.
REQ-026 Latency: res_valid SHALL rise N+1 cycles after the accepting edge for legal ops, 1 cycle for illegal ops.
REQ-027 alu_a/alu_b/alu_op SHALL remain stable from acceptance until the next acceptance.
REQ-028 In RESP, res_lo/res_hi/res_err SHALL stay stable while res_ready=0.
REQ-029 On RESP handshake, SHALL return to IDLE; if op was 10 or 11 and res_err=0, SHALL write hi_q<=res_hi, lo_q<=res_lo at that edge; otherwise hi_q/lo_q unchanged.
REQ-030 req_valid during EXEC/RESP SHALL be ignored (no overlap); a request offered in the RESP handshake cycle SHALL be accepted no earlier than the following IDLE cycle.
REQ-031 alu_zlow/alu_zhigh SHALL be sampled only at the capture edge; changes at other times SHALL have no effect.

Reset
REQ-032 clear=0 SHALL asynchronously force state IDLE, wait count 0, and alu_a, alu_b, alu_op, res_lo, res_hi, res_err, res_valid, hi_q, lo_q all to 0.
REQ-033 Reset mid-EXEC or mid-RESP SHALL discard the operation; req_ready SHALL be 1 in the first cycle after clear deasserts.

Structure
REQ-034 SHALL place opcode constants (OP_ADD=0, OP_AND=1, OP_OR=2, OP_SHL=3, OP_SHR=4, OP_SHRA=5, OP_ROL=6, OP_ROR=7, OP_NOT=8, OP_NEG=9, OP_MUL=10, OP_DIV=11, OP_LAST_LEGAL=11) and the state encoding in shared package alu_seq_pkg.
REQ-035 SHALL instantiate one sub-module alu_hilo_regs holding hi_q/lo_q with write-enable; the ALU itself SHALL be instantiated outside this block.

Verification (bench uses behavioural ALU model, MULDIV_WAIT=4)
REQ-036 op=0, A=5, B=7 -> res_valid 2 cycles after accept, res_lo=12, res_hi=0, res_err=0, hi_q/lo_q unchanged.
REQ-037 op=10, A=0x00010000, B=0x00010000 -> res_valid 5 cycles after accept, res_hi=1, res_lo=0; after handshake hi_q=1, lo_q=0.
REQ-038 op=11, A=17, B=5 -> res_lo=3, res_hi=2; after handshake lo_q=3, hi_q=2.
REQ-039 op=12, A=1, B=1 -> res_valid 1 cycle after accept, res_err=1, res_lo=res_hi=0, hi_q/lo_q unchanged.
REQ-040 res_ready held 0 for 10 cycles in RESP -> res_valid stays 1, res_lo/res_hi stable, req_ready 0, new req_valid ignored.
REQ-041 clear pulsed low in 2nd EXEC cycle of op=10 -> all outputs 0 immediately, req_ready=1 first cycle after release, no hi_q/lo_q write.
